// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial adder. One full_adder cell is reused WIDTH times, LSB first,
//   to compute {Cout, s} = a + b + Cin. Operands are captured on a start
//   handshake, and a one-cycle done pulse marks a new result.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only while idle
//   a, b   in   WIDTH-bit operands, captured on the accepting edge
//   Cin    in   carry-in, captured on the accepting edge
//   busy   out  high whenever the controller is not idle (registered)
//   done   out  one-cycle pulse, s/Cout hold the new result (registered)
//   s      out  WIDTH-bit sum (registered, holds the last result)
//   Cout   out  carry-out (registered, holds the last result)

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             Cout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] ra_reg, rb_reg, rs_reg;
  logic             cr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg, done_reg, busy_next, done_next;
  logic [WIDTH-1:0] s_reg;
  logic             cout_reg;

  logic             bit_s, bit_c;
  logic             last_bit;
  logic [WIDTH-1:0] ra_shift, rb_shift, rs_shift;

  full_adder u_fa (
    .a  (ra_reg[0]),
    .b  (rb_reg[0]),
    .ci (cr_reg),
    .s  (bit_s),
    .co (bit_c)
  );

  // Right-shift networks: operands shift in zeros, the sum register takes
  // the freshly computed bit at its MSB so that after WIDTH shifts bit 0 of
  // the result has travelled down to rs[0].
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign ra_shift[gi] = ra_reg[gi+1];
      assign rb_shift[gi] = rb_reg[gi+1];
      assign rs_shift[gi] = rs_reg[gi+1];
    end
  endgenerate
  assign ra_shift[WIDTH-1] = 1'b0;
  assign rb_shift[WIDTH-1] = 1'b0;
  assign rs_shift[WIDTH-1] = bit_s;

  assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

  // State register; busy/done are registered from the next state so that
  // no output has a combinational path from any input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode, evaluated on the state being entered
  always_comb begin
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_reg   <= '0;
      rb_reg   <= '0;
      rs_reg   <= '0;
      cr_reg   <= 1'b0;
      cnt_reg  <= '0;
      s_reg    <= '0;
      cout_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            ra_reg  <= a;
            rb_reg  <= b;
            cr_reg  <= Cin;
            cnt_reg <= '0;
          end
        end
        RUN: begin
          ra_reg  <= ra_shift;
          rb_reg  <= rb_shift;
          rs_reg  <= rs_shift;
          cr_reg  <= bit_c;
          cnt_reg <= cnt_reg + CNT_W'(1);
          // The final bit is folded straight into the published result.
          if (last_bit) begin
            s_reg    <= rs_shift;
            cout_reg <= bit_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign s    = s_reg;
  assign Cout = cout_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;

  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, s4;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, s8;

  int n_cmp;
  int n_err;

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .Cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .s     (s4),
    .Cout  (cout4)
  );

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .Cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .s     (s8),
    .Cout  (cout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_busy(input bit w8);
    return w8 ? busy8 : busy4;
  endfunction
  function automatic logic get_done(input bit w8);
    return w8 ? done8 : done4;
  endfunction
  function automatic logic get_cout(input bit w8);
    return w8 ? cout8 : cout4;
  endfunction
  function automatic logic [7:0] get_s(input bit w8);
    return w8 ? s8 : {4'b0000, s4};
  endfunction

  task automatic set_in(input bit w8, input logic st, input logic [7:0] av,
                        input logic [7:0] bv, input logic cv);
    if (w8) begin
      start8 = st; a8 = av; b8 = bv; cin8 = cv;
    end else begin
      start4 = st; a4 = av[3:0]; b4 = bv[3:0]; cin4 = cv;
    end
  endtask

  // One full transaction. Called at posedge+1; returns at posedge+1 in IDLE.
  // disturb: toggle start and drive all-ones operands while running.
  task automatic do_op(input bit w8, input logic [7:0] av, input logic [7:0] bv,
                       input logic cv, input logic [7:0] es, input logic ec,
                       input bit disturb, input string tag);
    logic [7:0] prev_s;
    logic       prev_c;
    int         k;
    int         w;
    bit         seen;
    bit         held_ok;
    w       = w8 ? 8 : 4;
    prev_s  = get_s(w8);
    prev_c  = get_cout(w8);
    set_in(w8, 1'b1, av, bv, cv);
    @(posedge clk); #1;                       // E0
    check($sformatf("%s_busy_e0", tag), get_busy(w8), 1);
    check($sformatf("%s_done_e0", tag), get_done(w8), 0);
    set_in(w8, 1'b0, av, bv, cv);
    k = 0; seen = 0; held_ok = 1;
    while (k < 20 && !seen) begin
      if (disturb) set_in(w8, k[0] ? 1'b0 : 1'b1, 8'hFF, 8'hFF, 1'b1);
      @(posedge clk); #1;
      k++;
      if (get_done(w8)) seen = 1;
      else if (!get_busy(w8) || get_s(w8) !== prev_s || get_cout(w8) !== prev_c)
        held_ok = 0;
    end
    set_in(w8, 1'b0, 8'h00, 8'h00, 1'b0);
    check($sformatf("%s_done_seen", tag), seen, 1);
    check($sformatf("%s_latency", tag), k, w);
    check($sformatf("%s_run_hold", tag), held_ok, 1);
    check($sformatf("%s_busy_done", tag), get_busy(w8), 1);
    check($sformatf("%s_s", tag), get_s(w8), es);
    check($sformatf("%s_cout", tag), get_cout(w8), ec);
    $display("op w=%0d a=%02h b=%02h cin=%0d -> s=%02h cout=%0d (exp %02h/%0d) lat=%0d",
             w, av, bv, cv, get_s(w8), get_cout(w8), es, ec, k);
    @(posedge clk); #1;                       // E0+W+1
    check($sformatf("%s_done_fall", tag), get_done(w8), 0);
    check($sformatf("%s_busy_fall", tag), get_busy(w8), 0);
    check($sformatf("%s_s_hold", tag), get_s(w8), es);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] sum;
    int         k;
    bit         ok;

    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b1;
    set_in(0, 1'b0, 8'h0, 8'h0, 1'b0);
    set_in(1, 1'b0, 8'h0, 8'h0, 1'b0);

    // Reset and idle
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_s", s4, 0);
    check("rst_cout", cout4, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("idle_%0d", i), {busy4, done4, cout4, s4}, 0);
    end

    // Basic and back-to-back results
    do_op(0, 8'h5, 8'h3, 1'b0, 8'h8, 1'b0, 0, "t5p3");
    do_op(0, 8'hF, 8'h1, 1'b0, 8'h0, 1'b1, 0, "tFp1");
    do_op(0, 8'hF, 8'hF, 1'b1, 8'hF, 1'b1, 0, "tFpFc");

    // Inputs disturbed during RUN
    do_op(0, 8'h1, 8'h1, 1'b0, 8'h2, 1'b0, 1, "dist");
    ok = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done4 || busy4) ok = 0;
    end
    check("dist_single_done", ok, 1);

    // Start held high: accepts every WIDTH+2 cycles
    set_in(0, 1'b1, 8'h2, 8'h3, 1'b0);
    k = 0;
    while (k < 20 && !done4) begin @(posedge clk); #1; k++; end
    check("hold_first_done", done4, 1);
    k = 0;
    do begin @(posedge clk); #1; k++; end while (k < 20 && !done4);
    check("hold_period", k, 6);
    check("hold_s", s4, 4'h5);
    set_in(0, 1'b0, 8'h0, 8'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1 check("hold_idle", busy4, 0);

    // Asynchronous reset mid-RUN at cnt==2
    set_in(0, 1'b1, 8'h3, 8'h1, 1'b0);
    @(posedge clk); #1;
    set_in(0, 1'b0, 8'h3, 8'h1, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy4, 0);
    check("mid_rst_done", done4, 0);
    check("mid_rst_s", s4, 0);
    check("mid_rst_cout", cout4, 0);
    ok = 1;
    repeat (3) begin
      @(posedge clk); #1;
      if (done4 || busy4) ok = 0;
    end
    check("mid_rst_quiet", ok, 1);
    rst_n = 1'b1;
    do_op(0, 8'h7, 8'h1, 1'b0, 8'h8, 1'b0, 0, "post_rst");

    // WIDTH=8 corners
    do_op(1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, "w8_zero");
    do_op(1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, "w8_max");
    do_op(1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0, "w8_msb");
    do_op(1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 0, "w8_ripple");
    do_op(1, 8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0, 0, "w8_nocarry");

    // WIDTH=8 random operands against the arithmetic sum
    for (int i = 0; i < 1000; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rc  = 1'($urandom_range(0, 1));
      sum = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
      do_op(1, ra, rb, rc, sum[7:0], sum[8], 0, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition controller that sequences one internal `full_adder` cell over WIDTH-bit operands, one bit per clock, LSB first. It sits beside the combinational ripple adder as a low-area alternative. A single shared full adder plus shift registers replaces WIDTH adder cells. Operands are captured on a start/done handshake, and the sum and carry-out are presented as registered outputs.

## Interface
- WIDTH, 4, operand and sum width in bits; legal range 2..32.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- Cin  input  1  carry-in; captured on the accepting edge
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse; s and Cout are valid
- s  output  WIDTH  registered sum
- Cout  output  1  registered carry-out

## Operation
- Internal storage:
  - shift registers ra and rb, each WIDTH bits
  - carry flop cr
  - sum shift register rs, WIDTH bits
  - bit counter cnt, width clog2(WIDTH)+1
  - state register
- One `full_adder` instance computes (ra[0], rb[0], cr) to (bit_s, bit_c).
- FSM states:
  - IDLE: busy=0, done=0. If start=1 at the edge: load ra=a, rb=b, cr=Cin, cnt=0, go to RUN. Otherwise stay.
  - RUN: busy=1. Each edge does all of the following:
    - ra and rb shift right by one
    - rs shifts right with bit_s entering at the MSB
    - cr takes bit_c
    - cnt increments
  - RUN exit: on the edge where cnt==WIDTH-1, perform the final shift, load s with the completed rs value (including this bit_s) and load Cout with bit_c, then go to DONE.
  - DONE: busy=1, done=1 for exactly one cycle. Next edge goes to IDLE unconditionally.
- start is ignored in RUN and DONE. Operand or Cin changes after acceptance have no effect.
- A start held high continuously is accepted again on the first edge in IDLE after DONE.
- s and Cout change only on the RUN-to-DONE edge. Otherwise they hold the last result, including across later IDLE periods and during a new RUN.
- Arithmetic: {Cout, s} = a + b + Cin, modulo 2^(WIDTH+1), computed exactly.
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE
  - busy=0, done=0, s=0, Cout=0
  - ra, rb, rs, cr, cnt cleared
  - A reset mid-RUN aborts the operation with no done pulse.
- Reset release: the first edge with rst_n=1 may accept start.

## Timing
- Let edge E0 be the edge that accepts start.
- Bit operations occur on edges E0+1 through E0+WIDTH.
- On edge E0+WIDTH: s and Cout update, and done rises.
- On edge E0+WIDTH+1: done falls and busy falls (IDLE).
- Earliest next accept is E0+WIDTH+2. Throughput is one operation per WIDTH+2 cycles.
- busy is high from E0 to E0+WIDTH+1, exclusive of the end edge.
- All outputs come directly from flops. There is no combinational path from inputs to outputs.

## Test plan
- Reset then idle, WIDTH=4: with rst_n low, busy=0, done=0, s=0000, Cout=0. After release with start=0 for 10 cycles, all outputs are unchanged.
- WIDTH=4, a=0101, b=0011, Cin=0, start pulsed at E0: done is high exactly during cycle E0+4 to E0+5, with s=1000 and Cout=0. busy is high from E0 to E0+5.
- WIDTH=4, a=1111, b=0001, Cin=0 gives s=0000, Cout=1. Then a=1111, b=1111, Cin=1 gives s=1111, Cout=1. The first result holds on s until the second done edge.
- Start toggled and a/b changed during RUN (a=0001, b=0001 accepted, then a=1111, b=1111 applied mid-run): the result is s=0010, Cout=0. Exactly one done pulse occurs. With start held high continuously, accepts happen every 6 cycles.
- Reset asserted asynchronously mid-RUN at cnt=2: busy, done, s and Cout go to 0 immediately, with no done pulse. After release, a new a=0111, b=0001 operation gives s=1000, Cout=0.
- WIDTH=8: 1000 random (a, b, Cin) triples plus the corners 00/FF/80 are checked against {Cout, s} = a + b + Cin. done occurs exactly 8 edges after each accept.
